// File: rtl/alu_step_pkg.sv
// Shared types and constants for the ALU response checker slice.
// Latency: n/a (package). Backpressure: n/a.
// Holds the default operand width, MISR polynomial/seed, FSM state enum and MISR step function.
package alu_step_pkg;

  localparam int          DEF_WIDTH = 4;
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // One MISR step: shift left, fold the polynomial back in when the MSB
  // falls out, then xor in the (zero-extended) response word.
  function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [15:0] din);
    logic [15:0] r;
    r = {sig[14:0], 1'b0};
    if (sig[15]) r = r ^ MISR_POLY;
    return r ^ din;
  endfunction

endpackage

// File: rtl/alu_misr16.sv
// 16-bit multiple-input signature register compacting DUT responses.
// Latency: signature reflects an enabled word one cycle after it is presented.
// Backpressure: none; en qualifies each word, idle cycles leave the signature unchanged.
// Ports: clk, rst (async, active-high), clr (reload SEED), en (absorb din), din[WIDTH-1:0], sig[15:0].
module alu_misr16
  import alu_step_pkg::*;
#(
  parameter int          WIDTH = DEF_WIDTH,
  parameter logic [15:0] SEED  = MISR_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [15:0]      sig
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= SEED;
    end else if (clr) begin
      sig <= SEED;
    end else if (en) begin
      sig <= misr_step(sig, 16'(din));
    end
  end

endmodule

// File: rtl/alu_resp_checker.sv
// Checks each applied (a, b, y) response against a|b, counts mismatches, compacts y into a MISR.
// Latency: one cycle per vector; done/pass assert one cycle after the final valid vector.
// Backpressure: none; vec_valid may have gaps of any length, vectors are consumed as offered.
// Ports: clk, rst (async, active-high), start, vec_valid, a, b, y in; busy, done, pass, err_count,
//        first_err_idx, err_seen, signature out. Optional ALU_RESP_SIG_CHECK_EN adds GOLDEN_SIG and
//        sig_match, and makes pass also require signature == GOLDEN_SIG.
module alu_resp_checker
  import alu_step_pkg::*;
#(
  parameter int          WIDTH   = DEF_WIDTH,
  parameter int          NUM_VEC = 32,
  parameter int          ERR_W   = 8,
  parameter logic [15:0] SEED    = MISR_SEED,
`ifdef ALU_RESP_SIG_CHECK_EN
  parameter logic [15:0] GOLDEN_SIG = 16'h0000,
`endif
  // A single-vector run still needs a 1-bit index register.
  localparam int         IDX_W   = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [IDX_W-1:0] first_err_idx,
  output logic             err_seen,
`ifdef ALU_RESP_SIG_CHECK_EN
  output logic             sig_match,
`endif
  output logic [15:0]      signature
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] vec_idx;
  logic             run_clr;
  logic             vec_acc;
  logic             mismatch;
  logic             last_vec;
  logic [ERR_W-1:0] err_nxt;

  always_comb begin
    // start is only honoured outside RUN; it clears the run state.
    run_clr  = start && (state != RUN);
    vec_acc  = vec_valid && (state == RUN);
    // Case inequality so X/Z on y is flagged rather than masked.
    mismatch = (y !== (a | b));
    last_vec = vec_acc && (vec_idx == IDX_W'(NUM_VEC - 1));
    err_nxt  = err_count;
    if (vec_acc && mismatch && (err_count != {ERR_W{1'b1}})) begin
      err_nxt = err_count + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)    state_nxt = RUN;
      RUN:     if (last_vec) state_nxt = DONE;
      DONE:    if (start)    state_nxt = RUN;
      default:               state_nxt = IDLE;
    endcase
  end

`ifdef ALU_RESP_SIG_CHECK_EN
  logic sig_ok_nxt;
  always_comb begin
    // Signature after the final vector lands, so pass can be registered with it.
    sig_ok_nxt = (misr_step(signature, 16'(y)) == GOLDEN_SIG);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_idx       <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      err_seen      <= 1'b0;
      pass          <= 1'b0;
`ifdef ALU_RESP_SIG_CHECK_EN
      sig_match     <= 1'b0;
`endif
    end else if (run_clr) begin
      vec_idx       <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      err_seen      <= 1'b0;
      pass          <= 1'b0;
`ifdef ALU_RESP_SIG_CHECK_EN
      sig_match     <= 1'b0;
`endif
    end else if (vec_acc) begin
      vec_idx   <= vec_idx + IDX_W'(1);
      err_count <= err_nxt;
      if (mismatch && !err_seen) begin
        first_err_idx <= vec_idx;
        err_seen      <= 1'b1;
      end
      if (last_vec) begin
`ifdef ALU_RESP_SIG_CHECK_EN
        pass      <= (err_nxt == '0) && sig_ok_nxt;
        sig_match <= sig_ok_nxt;
`else
        pass      <= (err_nxt == '0);
`endif
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  alu_misr16 #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (run_clr),
    .en  (vec_acc),
    .din (y),
    .sig (signature)
  );

endmodule

// File: tb/tb_alu_resp_checker.sv
// Self-checking bench for alu_resp_checker: default instance, NUM_VEC=1 instance, ERR_W=4 instance.
// Expected run results are built by a bench model as vectors are driven and queued; they are
// popped and compared when the checker reports done.
`timescale 1ns/1ps
module tb_alu_resp_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start_m = 1'b0, start_1 = 1'b0, start_4 = 1'b0;
  logic       vec_valid = 1'b0;
  logic [3:0] a = '0, b = '0, y = '0;

  logic busy_m, done_m, pass_m, seen_m;
  logic [7:0] err_m;
  logic [4:0] first_m;
  logic [15:0] sig_m;

  logic busy_1, done_1, pass_1, seen_1;
  logic [7:0] err_1;
  logic [0:0] first_1;
  logic [15:0] sig_1;

  logic busy_4, done_4, pass_4, seen_4;
  logic [3:0] err_4;
  logic [4:0] first_4;
  logic [15:0] sig_4;

`ifdef ALU_RESP_SIG_CHECK_EN
  logic sm_m, sm_1, sm_4;
`endif

  alu_resp_checker u_main (
    .clk(clk), .rst(rst), .start(start_m), .vec_valid(vec_valid), .a(a), .b(b), .y(y),
    .busy(busy_m), .done(done_m), .pass(pass_m), .err_count(err_m), .first_err_idx(first_m),
`ifdef ALU_RESP_SIG_CHECK_EN
    .sig_match(sm_m),
`endif
    .err_seen(seen_m), .signature(sig_m)
  );

  alu_resp_checker #(.NUM_VEC(1)) u_nv1 (
    .clk(clk), .rst(rst), .start(start_1), .vec_valid(vec_valid), .a(a), .b(b), .y(y),
    .busy(busy_1), .done(done_1), .pass(pass_1), .err_count(err_1), .first_err_idx(first_1),
`ifdef ALU_RESP_SIG_CHECK_EN
    .sig_match(sm_1),
`endif
    .err_seen(seen_1), .signature(sig_1)
  );

  alu_resp_checker #(.ERR_W(4)) u_e4 (
    .clk(clk), .rst(rst), .start(start_4), .vec_valid(vec_valid), .a(a), .b(b), .y(y),
    .busy(busy_4), .done(done_4), .pass(pass_4), .err_count(err_4), .first_err_idx(first_4),
`ifdef ALU_RESP_SIG_CHECK_EN
    .sig_match(sm_4),
`endif
    .err_seen(seen_4), .signature(sig_4)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- model + scoreboard ----------------
  typedef struct {
    int          err;
    int          first;
    bit          seen;
    bit          pass;
    logic [15:0] sig;
  } exp_t;

  exp_t sb[$];

  int          m_err, m_first, m_idx, m_cap;
  bit          m_seen;
  logic [15:0] m_sig;

  function automatic logic [15:0] misr_model(input logic [15:0] s, input logic [3:0] d);
    logic [15:0] r;
    r = {s[14:0], 1'b0};
    if (s[15]) r = r ^ 16'h1021;
    return r ^ {12'h000, d};
  endfunction

  task automatic model_clear(input int cap);
    m_err = 0; m_first = 0; m_idx = 0; m_cap = cap; m_seen = 0; m_sig = 16'hFFFF;
  endtask

  task automatic model_vec(input logic [3:0] ta, input logic [3:0] tb, input logic [3:0] ty);
    if (ty != (ta | tb)) begin
      if (!m_seen) begin
        m_first = m_idx;
        m_seen  = 1;
      end
      if (m_err < m_cap) m_err++;
    end
    m_sig = misr_model(m_sig, ty);
    m_idx++;
  endtask

  task automatic model_push();
    exp_t e;
    e.err = m_err; e.first = m_first; e.seen = m_seen; e.pass = (m_err == 0); e.sig = m_sig;
    sb.push_back(e);
  endtask

  // ---------------- observation ----------------
  task automatic observe(input int w, output logic [31:0] ob, output logic [31:0] od,
                         output logic [31:0] op, output logic [31:0] os, output logic [31:0] oe,
                         output logic [31:0] of, output logic [31:0] og);
    case (w)
      1: begin
        ob = 32'(busy_1); od = 32'(done_1); op = 32'(pass_1); os = 32'(seen_1);
        oe = 32'(err_1); of = 32'(first_1); og = 32'(sig_1);
      end
      2: begin
        ob = 32'(busy_4); od = 32'(done_4); op = 32'(pass_4); os = 32'(seen_4);
        oe = 32'(err_4); of = 32'(first_4); og = 32'(sig_4);
      end
      default: begin
        ob = 32'(busy_m); od = 32'(done_m); op = 32'(pass_m); os = 32'(seen_m);
        oe = 32'(err_m); of = 32'(first_m); og = 32'(sig_m);
      end
    endcase
  endtask

  task automatic check_reset_vals(input string tag);
    logic [31:0] ob, od, op, os, oe, of, og;
    observe(0, ob, od, op, os, oe, of, og);
    check({tag, ".busy"}, ob, 0);
    check({tag, ".done"}, od, 0);
    check({tag, ".pass"}, op, 0);
    check({tag, ".err_seen"}, os, 0);
    check({tag, ".err_count"}, oe, 0);
    check({tag, ".first_idx"}, of, 0);
    check({tag, ".sig"}, og, 32'h0000FFFF);
  endtask

  // Called at the falling edge right after the final vector was captured.
  task automatic compare_done(input int w, input string tag);
    logic [31:0] ob, od, op, os, oe, of, og;
    exp_t e;
    observe(w, ob, od, op, os, oe, of, og);
    check({tag, ".done_lat"}, od, 1);
    check({tag, ".busy"}, ob, 0);
    check({tag, ".sb_depth"}, 32'(sb.size()), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".err_count"}, oe, 32'(e.err));
      check({tag, ".first_idx"}, of, 32'(e.first));
      check({tag, ".err_seen"}, os, 32'(e.seen));
      check({tag, ".pass"}, op, 32'(e.pass));
      check({tag, ".sig"}, og, 32'(e.sig));
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic start_pulse(input int w);
    case (w)
      1:       start_1 = 1'b1;
      2:       start_4 = 1'b1;
      default: start_m = 1'b1;
    endcase
    @(negedge clk);
    start_m = 1'b0; start_1 = 1'b0; start_4 = 1'b0;
  endtask

  task automatic send(input logic [3:0] ta, input logic [3:0] tb, input logic [3:0] ty, input int gap);
    a = ta; b = tb; y = ty; vec_valid = 1'b1;
    model_vec(ta, tb, ty);
    @(negedge clk);
    vec_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // mode 0: correct; 1: fault at index 5; 2: all wrong; 3: errors at indices 2 and 7
  task automatic sweeps(input int mode, input int gap, input bit midstart, input int nvec);
    logic [3:0] ta, tb, ty;
    for (int i = 0; i < nvec; i++) begin
      ta = 4'(i % 16);
      tb = (i < 16) ? 4'b0011 : 4'b0101;
      ty = ta | tb;
      if (mode == 1 && i == 5) ty = 4'h6;
      if (mode == 2) ty = ~(ta | tb);
      if (mode == 3 && (i == 2 || i == 7)) ty = ty ^ 4'h1;
      if (midstart && i == 10) start_m = 1'b1;
      send(ta, tb, ty, (i == nvec - 1) ? 0 : gap);
      start_m = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    check("reset.nv1_sig", 32'(sig_1), 32'h0000FFFF);
    rst = 1'b0;
    @(negedge clk);

    // Gapless correct run
    model_clear(255);
    start_pulse(0);
    check("gapless.busy", 32'(busy_m), 1);
    sweeps(0, 0, 1'b0, 32);
    model_push();
    compare_done(0, "gapless");

    // Restart from DONE, fault at index 5
    model_clear(255);
    start_pulse(0);
    check("restart.busy", 32'(busy_m), 1);
    check("restart.err_clr", 32'(err_m), 0);
    check("restart.sig_seed", 32'(sig_m), 32'h0000FFFF);
    sweeps(1, 0, 1'b0, 32);
    model_push();
    compare_done(0, "fault5");

    // Gaps of 3 cycles plus a start pulse mid-run
    model_clear(255);
    start_pulse(0);
    sweeps(0, 3, 1'b1, 32);
    model_push();
    compare_done(0, "gap3");

    // Reset mid-run after 10 vectors with 2 errors
    model_clear(255);
    start_pulse(0);
    sweeps(3, 0, 1'b0, 10);
    check("midrun.busy", 32'(busy_m), 1);
    check("midrun.err_count", 32'(err_m), 32'(m_err));
    check("midrun.first_idx", 32'(first_m), 32'(m_first));
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst.busy", 32'(busy_m), 0);

    // Single-vector runs
    model_clear(255);
    start_pulse(1);
    send(4'h0, 4'h0, 4'h0, 0);
    model_push();
    compare_done(1, "nv1_zero");
    check("nv1_zero.sig_const", 32'(sig_1), 32'h0000EFDF);
    model_clear(255);
    start_pulse(1);
    send(4'h7, 4'h0, 4'h7, 0);
    model_push();
    compare_done(1, "nv1_seven");
    check("nv1_seven.sig_const", 32'(sig_1), 32'h0000EFD8);

    // ERR_W=4, every vector wrong
    model_clear(15);
    start_pulse(2);
    sweeps(2, 0, 1'b0, 32);
    model_push();
    compare_done(2, "sat");
    check("sat.err_const", 32'(err_4), 15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
